vend_level_sequencer: RTL and testbench

- Reverse-direction partner of the vending level encoder, which maps a 4-bit thermometer sensor word (0001/0011/0111/1111) to a 2-bit code.
- This block accepts a 2-bit target code through a valid/ready handshake.
- It drives a 4-bit thermometer output (slot indicator / actuator bank), ramping one bit per programmable step interval until the target level is reached, then pulses done.

---
 rtl/vend_level_sequencer.sv | 129 ++++++++++++
 tb/tb_vend_level_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/vend_level_sequencer.sv
// Target-level sequencer for a 4-bit thermometer drive: accepts a 2-bit code
// through valid/ready, ramps one bit per STEP_CYCLES interval, then pulses done.
module vend_level_sequencer #(
    parameter int STEP_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [1:0] in_code,
    output logic       in_ready,
    output logic [3:0] P_out,
    output logic [1:0] cur_code,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STEP_CYCLES - 1);

    state_t           state_q;
    logic [3:0]       p_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       target_q;
    logic             up_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;
    logic [3:0]       p_step_d;
    logic [1:0]       code_step_d;

    // Decode the present thermometer level into its code.
    always_comb begin
        case (p_q)
            4'b0001: cur_code = 2'd0;
            4'b0011: cur_code = 2'd1;
            4'b0111: cur_code = 2'd2;
            4'b1111: cur_code = 2'd3;
            default: cur_code = 2'd0;
        endcase
    end

    // One-bit step toward the target and the code that step lands on.
    always_comb begin
        if (up_q) begin
            p_step_d    = {p_q[2:0], 1'b1};
            code_step_d = cur_code + 2'd1;
        end else begin
            p_step_d    = {1'b0, p_q[3:1]};
            code_step_d = cur_code - 2'd1;
        end
    end

    // Sequencer FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            p_q      <= 4'b0001;
            cnt_q    <= '0;
            target_q <= 2'd0;
            up_q     <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && ready_q) begin
                        target_q <= in_code;
                        ready_q  <= 1'b0;
                        if (in_code == cur_code) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RAMP;
                            busy_q  <= 1'b1;
                            cnt_q   <= RELOAD;
                            up_q    <= (in_code > cur_code);
                        end
                    end else begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                RAMP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        p_q   <= p_step_d;
                        cnt_q <= RELOAD;
                        if (code_step_d == target_q) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RAMP;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    p_q     <= 4'b0001;
                    cnt_q   <= '0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = ready_q;
    assign P_out    = p_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_vend_level_sequencer.sv
// Directed bench for vend_level_sequencer: one instance with STEP_CYCLES=4 and
// one with STEP_CYCLES=1, selected by sel, checked against hand-derived timing.
module tb_vend_level_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel;
    logic       v;
    logic [1:0] c;

    logic       in_valid_4, in_ready_4, busy_4, done_4;
    logic [3:0] p_4;
    logic [1:0] code_4;
    logic       in_valid_1, in_ready_1, busy_1, done_1;
    logic [3:0] p_1;
    logic [1:0] code_1;

    logic       ready_s, busy_s, done_s;
    logic [3:0] p_s;
    logic [1:0] code_s;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign in_valid_4 = v & ~sel;
    assign in_valid_1 = v & sel;

    always_comb begin
        if (sel) begin
            ready_s = in_ready_1; busy_s = busy_1; done_s = done_1;
            p_s = p_1; code_s = code_1;
        end else begin
            ready_s = in_ready_4; busy_s = busy_4; done_s = done_4;
            p_s = p_4; code_s = code_4;
        end
    end

    vend_level_sequencer #(.STEP_CYCLES(4), .CNT_W(8)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_4), .in_code(c),
        .in_ready(in_ready_4), .P_out(p_4), .cur_code(code_4),
        .busy(busy_4), .done(done_4)
    );

    vend_level_sequencer #(.STEP_CYCLES(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_1), .in_code(c),
        .in_ready(in_ready_1), .P_out(p_1), .cur_code(code_1),
        .busy(busy_1), .done(done_1)
    );

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] lvl_to_p(input int l);
        case (l)
            0:       return 4'b0001;
            1:       return 4'b0011;
            2:       return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    task automatic check_idle(input string tag, input int lvl);
        check_val({tag, "_p"},     8'(p_s),     8'(lvl_to_p(lvl)));
        check_val({tag, "_code"},  8'(code_s),  8'(lvl));
        check_val({tag, "_ready"}, 8'(ready_s), 8'd1);
        check_val({tag, "_busy"},  8'(busy_s),  8'd0);
        check_val({tag, "_done"},  8'(done_s),  8'd0);
    endtask

    // Request to_c starting from level from_c; optionally pulse a stray request mid-ramp.
    task automatic run_ramp(input string tag, input int from_c, input int to_c,
                            input int sc, input bit glitch);
        int k;
        int lvl;
        k = (to_c > from_c) ? (to_c - from_c) : (from_c - to_c);
        v = 1'b1;
        c = 2'(to_c);
        tick();
        v = 1'b0;
        if (k == 0) begin
            check_val({tag, "_same_done"},  8'(done_s),  8'd1);
            check_val({tag, "_same_p"},     8'(p_s),     8'(lvl_to_p(from_c)));
            check_val({tag, "_same_ready"}, 8'(ready_s), 8'd0);
            check_val({tag, "_same_busy"},  8'(busy_s),  8'd0);
        end else begin
            check_val({tag, "_acc_busy"},  8'(busy_s),  8'd1);
            check_val({tag, "_acc_ready"}, 8'(ready_s), 8'd0);
            check_val({tag, "_acc_p"},     8'(p_s),     8'(lvl_to_p(from_c)));
            for (int t = 1; t <= k * sc; t++) begin
                if (glitch && t == 2) begin
                    v = 1'b1;
                    c = 2'd0;
                end
                tick();
                v = 1'b0;
                lvl = (to_c > from_c) ? (from_c + t / sc) : (from_c - t / sc);
                check_val({tag, "_p"},     8'(p_s),     8'(lvl_to_p(lvl)));
                check_val({tag, "_code"},  8'(code_s),  8'(lvl));
                check_val({tag, "_ready"}, 8'(ready_s), 8'd0);
                if (t < k * sc) begin
                    check_val({tag, "_busy"}, 8'(busy_s), 8'd1);
                    check_val({tag, "_done"}, 8'(done_s), 8'd0);
                end else begin
                    check_val({tag, "_end_busy"}, 8'(busy_s), 8'd0);
                    check_val({tag, "_end_done"}, 8'(done_s), 8'd1);
                end
            end
        end
        tick();
        check_idle({tag, "_after"}, to_c);
    endtask

    initial begin
        rst_n = 1'b0;
        sel   = 1'b0;
        v     = 1'b0;
        c     = 2'd0;
        tick();
        tick();
        rst_n = 1'b1;
        check_idle("reset", 0);
        tick();
        check_idle("post_reset", 0);

        run_ramp("up4", 0, 3, 4, 1'b0);
        run_ramp("down4_glitch", 3, 1, 4, 1'b1);
        run_ramp("same4", 1, 1, 4, 1'b0);

        // Back to level 0, then abandon a 0->3 ramp with reset at T+6.
        run_ramp("down4_to0", 1, 0, 4, 1'b0);
        v = 1'b1;
        c = 2'd3;
        tick();
        v = 1'b0;
        for (int t = 1; t <= 5; t++) tick();
        check_val("mid_p_t5", 8'(p_s), 8'(4'b0011));
        rst_n = 1'b0;
        tick();
        check_idle("mid_reset", 0);
        rst_n = 1'b1;
        for (int t = 0; t < 10; t++) begin
            tick();
            check_val("mid_no_done", 8'(done_s), 8'd0);
        end
        check_idle("mid_settled", 0);

        sel = 1'b1;
        check_idle("sc1_start", 0);
        run_ramp("up1", 0, 3, 1, 1'b0);
        run_ramp("down1_b2b", 3, 0, 1, 1'b0);
        run_ramp("up1_mid", 0, 2, 1, 1'b1);
        run_ramp("same1", 2, 2, 1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
